// File: rtl/fp_pkg.sv
// Shared types and constants for the FP add/sub back end: FSM states, field widths and the packed float layout.
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_SIG_W  = FP_FRAC_W + 2;
    localparam int EXP_BIAS  = 127;
    localparam int EXP_MAX   = 255;

    typedef enum logic [2:0] {
        IDLE,
        RSHIFT,
        LSHIFT,
        ROUND,
        OUT
    } state_t;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp_float_t;

endpackage

// File: rtl/fp_normalize_pack_if.sv
// Operand-in / result-out handshake bundle between the adder core and the normalize/pack stage.
interface fp_normalize_pack_if
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [FRAC_W+1:0]       in_sig;
    logic [2:0]              in_grs;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_result;
    logic                    out_overflow;
    logic                    out_underflow;
    logic                    out_inexact;
    logic                    out_zero;

    modport master (
        output in_valid, in_sign, in_exp, in_sig, in_grs, out_ready,
        input  in_ready, out_valid, out_result, out_overflow,
               out_underflow, out_inexact, out_zero
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, in_grs, out_ready,
        output in_ready, out_valid, out_result, out_overflow,
               out_underflow, out_inexact, out_zero
    );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a significand; purely combinational.
// The top bit of sig is expected clear so a rounding carry lands in sig_rnd's MSB.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int SIG_W = FP_SIG_W
) (
    input  logic [SIG_W-1:0] sig,
    input  logic             g,
    input  logic             r,
    input  logic             s,
    output logic [SIG_W-1:0] sig_rnd,
    output logic             carry,
    output logic             inexact
);
    logic inc;

    // Ties (g set, r and s clear) round up only when the LSB is odd.
    assign inc     = g & (r | s | sig[0]);
    assign sig_rnd = sig + {{(SIG_W-1){1'b0}}, inc};
    assign carry   = sig_rnd[SIG_W-1];
    assign inexact = g | r | s;

endmodule

// File: rtl/fp_normalize_pack.sv
// Normalize (1 bit/cycle), round RNE and pack a raw sum into IEEE single; latency 1 (zero) / 2 + shift cycles.
// One op in flight: in_ready only in IDLE; the result is held until out_ready.
module fp_normalize_pack
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input logic              clk,
    input logic              rst_n,
    fp_normalize_pack_if.slave bus
);
    localparam int SIG_W = FRAC_W + 2;
    localparam int XW    = EXP_W + 2;
    localparam int RES_W = 1 + EXP_W + FRAC_W;
    localparam int HID   = FRAC_W;
    localparam int CW    = $clog2(FRAC_W + 1);

    localparam logic signed [XW-1:0] EXP_TOP   = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ONE   = XW'(1);
    localparam logic [CW-1:0]        SHIFT_MAX = CW'(FRAC_W);

    state_t                 state, state_nxt;
    logic                   sign_q, sign_nxt;
    logic signed [XW-1:0]   exp_q, exp_nxt;
    logic [SIG_W-1:0]       sig_q, sig_nxt;
    logic                   g_q, g_nxt;
    logic                   r_q, r_nxt;
    logic                   s_q, s_nxt;
    logic [CW-1:0]          cnt_q, cnt_nxt;
    logic [RES_W-1:0]       res_q, res_nxt;
    logic                   ovf_q, ovf_nxt;
    logic                   unf_q, unf_nxt;
    logic                   inx_q, inx_nxt;
    logic                   zero_q, zero_nxt;
    logic                   in_ready_q, in_ready_nxt;
    logic                   out_valid_q, out_valid_nxt;

    logic [SIG_W-1:0]       rnd_sig;
    logic                   rnd_carry;
    logic                   rnd_inexact;
    logic [SIG_W-2:0]       norm_sig;
    logic signed [XW-1:0]   norm_exp;
    logic signed [XW-1:0]   exp_inc;
    logic signed [XW-1:0]   exp_dec;
    logic [EXP_W-1:0]       pack_exp;
    logic [FRAC_W-1:0]      pack_frac;

    fp_round_rne #(.SIG_W(SIG_W)) u_round (
        .sig     (sig_q),
        .g       (g_q),
        .r       (r_q),
        .s       (s_q),
        .sig_rnd (rnd_sig),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    assign exp_inc   = exp_q + EXP_ONE;
    assign exp_dec   = exp_q - EXP_ONE;
    assign norm_sig  = rnd_carry ? rnd_sig[SIG_W-1:1] : rnd_sig[SIG_W-2:0];
    assign norm_exp  = rnd_carry ? exp_inc : exp_q;
    // A denormal that rounds up into the hidden bit picks up exp field 1 here.
    assign pack_exp  = norm_sig[HID] ? norm_exp[EXP_W-1:0] : '0;
    assign pack_frac = norm_sig[FRAC_W-1:0];

    always_comb begin
        state_nxt = state;
        sign_nxt  = sign_q;
        exp_nxt   = exp_q;
        sig_nxt   = sig_q;
        g_nxt     = g_q;
        r_nxt     = r_q;
        s_nxt     = s_q;
        cnt_nxt   = cnt_q;
        res_nxt   = res_q;
        ovf_nxt   = ovf_q;
        unf_nxt   = unf_q;
        inx_nxt   = inx_q;
        zero_nxt  = zero_q;

        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sign_nxt              = bus.in_sign;
                    exp_nxt               = $signed({2'b00, bus.in_exp});
                    sig_nxt               = bus.in_sig;
                    {g_nxt, r_nxt, s_nxt} = bus.in_grs;
                    cnt_nxt               = '0;
                    if (bus.in_sig == '0 && bus.in_grs == 3'b000) begin
                        state_nxt = OUT;
                        res_nxt   = {bus.in_sign, {(EXP_W+FRAC_W){1'b0}}};
                        ovf_nxt   = 1'b0;
                        unf_nxt   = 1'b0;
                        inx_nxt   = 1'b0;
                        zero_nxt  = 1'b1;
                    end else if (bus.in_sig[SIG_W-1]) begin
                        state_nxt = RSHIFT;
                    end else if (!bus.in_sig[HID]) begin
                        state_nxt = LSHIFT;
                    end else begin
                        state_nxt = ROUND;
                    end
                end
            end

            RSHIFT: begin
                sig_nxt = sig_q >> 1;
                g_nxt   = sig_q[0];
                r_nxt   = g_q;
                s_nxt   = s_q | r_q;
                exp_nxt = exp_inc;
                if (exp_inc >= EXP_TOP) begin
                    state_nxt = OUT;
                    res_nxt   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    ovf_nxt   = 1'b1;
                    unf_nxt   = 1'b0;
                    inx_nxt   = 1'b1;
                    zero_nxt  = 1'b0;
                end else begin
                    state_nxt = ROUND;
                end
            end

            LSHIFT: begin
                // Already at the minimum exponent: leave it denormal rather than shift.
                if (exp_q == EXP_ONE || cnt_q == SHIFT_MAX) begin
                    state_nxt = ROUND;
                end else begin
                    sig_nxt = {sig_q[SIG_W-2:0], g_q};
                    g_nxt   = r_q;
                    r_nxt   = 1'b0;
                    exp_nxt = exp_dec;
                    cnt_nxt = cnt_q + CW'(1);
                    if (sig_q[HID-1] || exp_dec == EXP_ONE || cnt_q + CW'(1) == SHIFT_MAX) begin
                        state_nxt = ROUND;
                    end
                end
            end

            ROUND: begin
                state_nxt = OUT;
                if (norm_exp >= EXP_TOP) begin
                    res_nxt  = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    ovf_nxt  = 1'b1;
                    unf_nxt  = 1'b0;
                    inx_nxt  = 1'b1;
                    zero_nxt = 1'b0;
                end else begin
                    res_nxt  = {sign_q, pack_exp, pack_frac};
                    ovf_nxt  = 1'b0;
                    unf_nxt  = (pack_exp == '0) && rnd_inexact && (pack_frac != '0);
                    inx_nxt  = rnd_inexact;
                    zero_nxt = (pack_exp == '0) && (pack_frac == '0);
                end
            end

            OUT: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase

        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == OUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            sign_q      <= sign_nxt;
            exp_q       <= exp_nxt;
            sig_q       <= sig_nxt;
            g_q         <= g_nxt;
            r_q         <= r_nxt;
            s_q         <= s_nxt;
            cnt_q       <= cnt_nxt;
            res_q       <= res_nxt;
            ovf_q       <= ovf_nxt;
            unf_q       <= unf_nxt;
            inx_q       <= inx_nxt;
            zero_q      <= zero_nxt;
            in_ready_q  <= in_ready_nxt;
            out_valid_q <= out_valid_nxt;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = res_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign bus.out_inexact   = inx_q;
    assign bus.out_zero      = zero_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Scoreboard bench for fp_normalize_pack: directed vectors, queued expectations, decoupled monitor.
module tb_fp_normalize_pack;
    import fp_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;   // {overflow, underflow, inexact, zero}
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   errs;
    int   chks;
    int   first_cyc;
    bit   prev_vld;
    exp_t sb[$];

    fp_normalize_pack_if #(.EXP_W(8), .FRAC_W(23)) bus ();

    fp_normalize_pack #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        chks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Monitor: pops one expectation per accepted result.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (bus.out_valid && !prev_vld) first_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chks++;
                    errs++;
                    $display("FAIL unexpected_result got=%08h expected=none", bus.out_result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 64'(bus.out_result), 64'(e.res));
                    check("flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_zero}),
                          64'(e.flags));
                    check("latency", 64'(first_cyc - e.acc), 64'(e.lat));
                end
            end
            prev_vld = bus.out_valid;
        end
    end

    task automatic send(input logic sgn, input logic [7:0] e, input logic [24:0] sg, input logic [2:0] grs,
                        input logic [31:0] res, input logic [3:0] flags, input int lat, input bit push);
        int   t;
        exp_t x;
        @(negedge clk);
        bus.in_sign  = sgn;
        bus.in_exp   = e;
        bus.in_sig   = sg;
        bus.in_grs   = grs;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chks++;
        if (!bus.in_ready) begin
            errs++;
            $display("FAIL accept_timeout got=in_ready=0 expected=1");
        end else if (push) begin
            x.res   = res;
            x.flags = flags;
            x.lat   = lat;
            x.acc   = cyc;
            sb.push_back(x);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        errs = 0;
        chks = 0;
        first_cyc = 0;
        prev_vld = 1'b0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_sig    = '0;
        bus.in_grs    = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.out_result), 64'd0);
        check("rst_flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_zero}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 64'(bus.in_ready), 64'd1);

        // sign, exp, sig, grs -> result, {ovf,unf,inx,zero}, latency
        send(0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 4'b0000, 3, 1);
        send(0, 8'd127, 25'h0800000, 3'b000, 32'h3F800000, 4'b0000, 2, 1);
        send(0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 4'b0010, 2, 1);
        send(0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 4'b0010, 2, 1);
        send(0, 8'd127, 25'h0800000, 3'b101, 32'h3F800001, 4'b0010, 2, 1);
        send(1, 8'd127, 25'h0800001, 3'b011, 32'hBF800001, 4'b0010, 2, 1);
        send(0, 8'd127, 25'h1000001, 3'b000, 32'h40000000, 4'b0010, 3, 1);
        send(0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 4'b0010, 3, 1);
        send(0, 8'd130, 25'h0000001, 3'b000, 32'h35800000, 4'b0000, 25, 1);
        send(0, 8'd10,  25'h0000001, 3'b000, 32'h00000200, 4'b0000, 11, 1);
        send(0, 8'd5,   25'h0000001, 3'b000, 32'h00000010, 4'b0000, 6, 1);
        send(0, 8'd1,   25'h0000003, 3'b100, 32'h00000004, 4'b0110, 3, 1);
        send(0, 8'd1,   25'h07FFFFF, 3'b110, 32'h00800000, 4'b0010, 3, 1);
        send(0, 8'd254, 25'h1FFFFFF, 3'b000, 32'h7F800000, 4'b1010, 2, 1);
        send(0, 8'd254, 25'h0FFFFFF, 3'b100, 32'h7F800000, 4'b1010, 2, 1);
        send(1, 8'd1,   25'h0000000, 3'b000, 32'h80000000, 4'b0001, 1, 1);
        drain();

        // Backpressure: result held, no new accept while stalled.
        bus.out_ready = 1'b0;
        send(0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 4'b0010, 2, 1);
        begin
            int t;
            t = 0;
            while (!bus.out_valid && t < 50) begin
                @(negedge clk);
                t++;
            end
        end
        check("bp_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.in_sign  = 1'b1;
                bus.in_exp   = 8'd100;
                bus.in_sig   = 25'h0C00000;
                bus.in_grs   = 3'b000;
                bus.in_valid = 1'b1;
            end
            check("bp_result", 64'(bus.out_result), 64'h3F800002);
            check("bp_flags", 64'({bus.out_overflow, bus.out_underflow, bus.out_inexact, bus.out_zero}), 64'h2);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        drain();

        // Reset during a long left shift: operation aborted, nothing emitted.
        send(0, 8'd130, 25'h0000001, 3'b000, 32'h0, 4'b0000, 0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (40) @(negedge clk);

        send(1, 8'd128, 25'h0C00000, 3'b000, 32'hC0400000, 4'b0000, 2, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
